// File: rtl/rsa_expt_initiator_pkg.sv
// Shared definitions for the modexp requester: Gray-coded controller states and width helpers.
package rsa_expt_initiator_pkg;

    // Gray sequence IDLE -> LAUNCH -> WAIT -> STORE keeps one bit flipping per step.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b11,
        ST_STORE  = 2'b10
    } state_e;

    function automatic int unsigned width_of(input int unsigned msb);
        return 2 ** (msb + 1);
    endfunction

    function automatic logic [1:0] gray(input logic [1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/rsa_result_fifo.sv
// Result FIFO: DEPTH x W storage with registered head, occupancy count and clock-enable.
module rsa_result_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = enable & push & (cnt_q != FULL);
    assign do_pop  = enable & pop & (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rsa_expt_initiator.sv
// Requester for the modexp engine: toggle-req/level-ack launch, key registers, launch
// timeout and a result FIFO towards the downstream stream.
module rsa_expt_initiator
    import rsa_expt_initiator_pkg::*;
#(
    parameter int unsigned I_MSB = 2,
    parameter int unsigned J_MSB = 10,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned LTO   = 7
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic                          key_load,
    input  logic [width_of(J_MSB)-1:0]    key_e,
    input  logic [width_of(I_MSB)-1:0]    key_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [width_of(I_MSB)-1:0]    in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [width_of(I_MSB)-1:0]    out_data,
    output logic                          mx_req,
    input  logic                          mx_ack,
    output logic [width_of(I_MSB)-1:0]    mx_a,
    output logic [width_of(J_MSB)-1:0]    mx_b,
    output logic [width_of(I_MSB)-1:0]    mx_n,
    input  logic [width_of(I_MSB)-1:0]    mx_result,
    output logic                          busy,
    output logic                          err,
    output logic [1:0]                    cst
);

    localparam int unsigned W  = width_of(I_MSB);
    localparam int unsigned EW = width_of(J_MSB);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (LTO > 0) ? $clog2(LTO + 1) : 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [TW-1:0] LTO_CNT = TW'(LTO);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [W-1:0]    a_q, a_d;
    logic [EW-1:0]   e_q, e_d;
    logic [W-1:0]    n_q, n_d;
    logic            key_vld_q, key_vld_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic            push;
    logic            accept;
    logic [CW-1:0]   fifo_cnt;

    // key_load masks in_ready so a new key and a launch never share a cycle.
    assign in_ready = (state_q == ST_IDLE) & key_vld_q & (fifo_cnt < FULL) & enable & ~key_load;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        a_d       = a_q;
        e_d       = e_q;
        n_d       = n_q;
        key_vld_d = key_vld_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        push      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (key_load) begin
                    e_d       = key_e;
                    n_d       = key_n;
                    key_vld_d = 1'b1;
                end else if (accept) begin
                    a_d      = in_data;
                    req_d    = ~req_q;
                    to_cnt_d = '0;
                    state_d  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!mx_ack) begin
                    state_d = ST_WAIT;
                end else if (to_cnt_q == LTO_CNT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_WAIT: begin
                if (mx_ack) begin
                    state_d = ST_STORE;
                end
            end
            ST_STORE: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (key_load && state_q != ST_IDLE) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            a_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            key_vld_q <= 1'b0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            req_q     <= req_d;
            a_q       <= a_d;
            e_q       <= e_d;
            n_q       <= n_d;
            key_vld_q <= key_vld_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
        end
    end

    rsa_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .push      (push),
        .push_data (mx_result),
        .pop       (out_ready),
        .head      (out_data),
        .cnt       (fifo_cnt)
    );

    assign out_valid = (fifo_cnt != '0);
    assign mx_req    = req_q;
    assign mx_a      = a_q;
    assign mx_b      = e_q;
    assign mx_n      = n_q;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign cst       = state_q;

endmodule
